regfile_2r1w_clr: RTL and testbench
===================================

// Module: regfile_2r1w_clr
// PURPOSE
//  Parametrised register file: one write port with byte enables, two independent registered
//  read ports (A, B), optional write-to-read bypass, and a sequential bulk-clear engine.
//  Next-generation general-purpose register storage for datapath and control blocks.
//  Replaces fixed 8-entry single-port register files.
// PARAMETERS
//  WIDTH   16  data width in bits; must be a multiple of 8 (NB = WIDTH/8 byte lanes)
//  DEPTH   16  number of entries; any value from 2 to 2**ADDR_W
//  ADDR_W  4   address width; addresses >= DEPTH are out of range
//  BYPASS  1   1: a same-cycle write to the read address is forwarded; 0: old data is returned
// PORTS
//  clk      in   1       clock; all logic on posedge
//  rst      in   1       synchronous reset, active-high
//  wrEN     in   1       write request
//  wrAddr   in   ADDR_W  write address
//  wrData   in   WIDTH   write data
//  wrBE     in   NB      byte enables; bit i covers wrData[8i+7:8i]
//  rdENa    in   1       read request, port A
//  rdAddrA  in   ADDR_W  read address, port A
//  rdDataA  out  WIDTH   registered read data, port A
//  rdValidA out  1       rdDataA valid (1-cycle pulse)
//  rdENb    in   1       read request, port B
//  rdAddrB  in   ADDR_W  read address, port B
//  rdDataB  out  WIDTH   registered read data, port B
//  rdValidB out  1       rdDataB valid (1-cycle pulse)
//  clrReq   in   1       start a bulk clear (level sampled at posedge)
//  busy     out  1       clear in progress
//  clrDone  out  1       1-cycle pulse when the clear completes
//  addrErr  out  1       1-cycle pulse: an out-of-range access occurred on the previous edge
// BEHAVIOUR
//  Reset: at a posedge with rst=1, all entries, rdDataA/B, rdValidA/B, busy, clrDone and
//   addrErr are set to 0, and the FSM enters IDLE. Reset overrides every other input and
//   aborts a clear in progress.
//  Write: at a posedge with wrEN=1, busy=0, clrReq=0 and wrAddr<DEPTH, each lane with wrBE=1
//   is updated; other lanes hold. wrBE=0 with wrEN=1 is a legal no-op.
//  Read latency: 1 cycle. rdENx=1 at edge N -> rdDatax and rdValidx=1 after edge N.
//   With rdENx=0, rdValidx=0 and rdDatax holds its last value.
//  Ports A and B are fully independent; both may read the same address in the same cycle.
//  Same-cycle write and read of one in-range address: with BYPASS=1, the read returns
//   {new data on enabled lanes, old data on the other lanes}; with BYPASS=0, it returns
//   pre-write contents.
//  Out of range: a write is dropped. A read returns rdData=0 with rdValid=1. addrErr=1
//   after that edge; any port may trigger it, and several faults still give one pulse.
//  FSM: IDLE -> CLEAR on clrReq=1 in IDLE. CLEAR zeroes entry cnt at each edge, with cnt
//   running 0..DEPTH-1. After zeroing DEPTH-1: -> IDLE, busy=0 and clrDone=1 for one cycle.
//   busy=1 for exactly DEPTH cycles.
//  During CLEAR: wrEN is ignored (dropped, no error). clrReq is ignored.
//  During CLEAR, reads are served normally: already-cleared entries read 0, others read old data.
//   A read of entry cnt in the cycle it is being cleared returns 0 when BYPASS=1.
//  A write in the same cycle as an accepted clrReq is dropped.
// TESTING
//  T1 wrEN, addr 0, data 16'h0005, BE=2'b11; next cycle rdENa, addr 0 -> rdDataA=5 and
//   rdValidA=1 one cycle later.
//  T2 write 13->1, 25->5, 9->7; rdENa addr1 and rdENb addr5 in the same cycle ->
//   A=13, B=25; then A addr7 -> 9.
//  T3 entry 3 = 16'hABCD; write 16'h1234 with BE=2'b01 -> reads 16'hAB34.
//   Same cycle, BE=2'b10, 16'h5600, with rdENa addr3 -> A=16'h5634 (BYPASS=1).
//  T4 wrEN=0 with wrData=98 on addr 0 -> entry 0 still reads 5. wrAddr=ADDR_W'hF with
//   DEPTH=12 -> no write, and addrErr pulses once.
//  T5 clrReq -> busy high for exactly DEPTH cycles; wrEN of 77 to addr 2 mid-clear is
//   dropped; clrDone pulses; then all entries read 0.
//  T6 rst=1 for 1 cycle mid-clear and mid-read -> all outputs 0 at the next cycle and
//   busy=0; entry 0 reads 0.

Source files
------------

// File: rtl/regfile_2r1w_clr.sv
// regfile_2r1w_clr
//   Parametrised register file with one byte-enabled write port and two
//   independent registered read ports (A, B). It has an optional
//   write-to-read bypass and a sequential bulk-clear engine that zeroes one
//   entry per cycle.
// Ports
//   clk, rst                 clock (posedge) / synchronous active-high reset
//   wrEN, wrAddr, wrData,    write request, address, data, per-byte enables
//   wrBE
//   rdENa, rdAddrA           port A read request / address
//   rdDataA, rdValidA        port A registered data / 1-cycle valid pulse
//   rdENb, rdAddrB           port B read request / address
//   rdDataB, rdValidB        port B registered data / 1-cycle valid pulse
//   clrReq                   start a bulk clear (level sampled in IDLE)
//   busy, clrDone            clear in progress / 1-cycle completion pulse
//   addrErr                  1-cycle pulse after any out-of-range access
module regfile_2r1w_clr #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wrEN,
  input  logic [ADDR_W-1:0]     wrAddr,
  input  logic [WIDTH-1:0]      wrData,
  input  logic [WIDTH/8-1:0]    wrBE,
  input  logic                  rdENa,
  input  logic [ADDR_W-1:0]     rdAddrA,
  output logic [WIDTH-1:0]      rdDataA,
  output logic                  rdValidA,
  input  logic                  rdENb,
  input  logic [ADDR_W-1:0]     rdAddrB,
  output logic [WIDTH-1:0]      rdDataB,
  output logic                  rdValidB,
  input  logic                  clrReq,
  output logic                  busy,
  output logic                  clrDone,
  output logic                  addrErr
);

  localparam int unsigned       NB      = WIDTH / 8;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [WIDTH-1:0]  rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0]  rd_data_b_q, rd_data_b_d;
  logic              rd_valid_a_q, rd_valid_a_d;
  logic              rd_valid_b_q, rd_valid_b_d;
  logic              busy_q, busy_d;
  logic              clr_done_q, clr_done_d;
  logic              addr_err_q, addr_err_d;

  logic              wr_in_range, a_in_range, b_in_range, wr_err;

  always_comb begin
    wr_in_range = ({1'b0, wrAddr}  < DEPTH_L);
    a_in_range  = ({1'b0, rdAddrA} < DEPTH_L);
    b_in_range  = ({1'b0, rdAddrB} < DEPTH_L);
  end

  // Storage and clear FSM. mem_d is the post-edge array contents; it is
  // also what the bypassed read ports sample, so forwarding of merged
  // write lanes and of the entry being cleared comes from a single place.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_done_d = 1'b0;
    wr_err     = 1'b0;
    mem_d      = mem_q;
    case (state_q)
      S_IDLE: begin
        wr_err = wrEN && !wr_in_range;
        if (clrReq) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else if (wrEN && wr_in_range) begin
          for (int unsigned i = 0; i < NB; i++) begin
            if (wrBE[i]) mem_d[wrAddr][8*i +: 8] = wrData[8*i +: 8];
          end
        end
      end
      S_CLEAR: begin
        mem_d[cnt_q] = '0;
        if (cnt_q == LAST) begin
          state_d    = S_IDLE;
          clr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CLEAR);
  end

  // Read ports: out-of-range reads return zero but still assert valid.
  always_comb begin
    rd_data_a_d  = rd_data_a_q;
    rd_data_b_d  = rd_data_b_q;
    rd_valid_a_d = rdENa;
    rd_valid_b_d = rdENb;
    if (rdENa) begin
      if (!a_in_range)      rd_data_a_d = '0;
      else if (BYPASS != 0) rd_data_a_d = mem_d[rdAddrA];
      else                  rd_data_a_d = mem_q[rdAddrA];
    end
    if (rdENb) begin
      if (!b_in_range)      rd_data_b_d = '0;
      else if (BYPASS != 0) rd_data_b_d = mem_d[rdAddrB];
      else                  rd_data_b_d = mem_q[rdAddrB];
    end
    addr_err_d = wr_err || (rdENa && !a_in_range) || (rdENb && !b_in_range);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mem_q        <= '{default: '0};
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
      busy_q       <= 1'b0;
      clr_done_q   <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_q        <= mem_d;
      rd_data_a_q  <= rd_data_a_d;
      rd_data_b_q  <= rd_data_b_d;
      rd_valid_a_q <= rd_valid_a_d;
      rd_valid_b_q <= rd_valid_b_d;
      busy_q       <= busy_d;
      clr_done_q   <= clr_done_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign rdDataA  = rd_data_a_q;
  assign rdDataB  = rd_data_b_q;
  assign rdValidA = rd_valid_a_q;
  assign rdValidB = rd_valid_b_q;
  assign busy     = busy_q;
  assign clrDone  = clr_done_q;
  assign addrErr  = addr_err_q;

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// tb_regfile_2r1w_clr
//   Scoreboard bench for regfile_2r1w_clr (WIDTH=16, DEPTH=12, ADDR_W=4,
//   BYPASS=1). The driver applies directed and random stimulus and pushes the
//   expected responses from a behavioural model; a monitor pops them and
//   compares against the DUT outputs.
module tb_regfile_2r1w_clr;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 12;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst, wrEN, rdENa, rdENb, clrReq;
  logic [AW-1:0] wrAddr, rdAddrA, rdAddrB;
  logic [W-1:0]  wrData, rdDataA, rdDataB;
  logic [1:0]    wrBE;
  logic          rdValidA, rdValidB, busy, clrDone, addrErr;

  regfile_2r1w_clr #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .wrEN(wrEN), .wrAddr(wrAddr), .wrData(wrData),
    .wrBE(wrBE), .rdENa(rdENa), .rdAddrA(rdAddrA), .rdDataA(rdDataA),
    .rdValidA(rdValidA), .rdENb(rdENb), .rdAddrB(rdAddrB), .rdDataB(rdDataB),
    .rdValidB(rdValidB), .clrReq(clrReq), .busy(busy), .clrDone(clrDone),
    .addrErr(addrErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic busy, done, err, va, vb, zero;
  } st_t;

  st_t          sq[$];
  logic [W-1:0] qa[$], qb[$];

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [W-1:0] m [D];
  bit           clr_act;
  int           clr_idx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: apply inputs, predict the post-edge outputs, wait for the edge.
  task automatic cyc(input logic r, input logic we, input int wa, input logic [W-1:0] wd,
                     input logic [1:0] be, input logic ea, input int aa,
                     input logic eb, input int ab, input logic cr);
    logic [W-1:0] nm [D];
    st_t s;
    rst = r; wrEN = we; wrAddr = AW'(wa); wrData = wd; wrBE = be;
    rdENa = ea; rdAddrA = AW'(aa); rdENb = eb; rdAddrB = AW'(ab); clrReq = cr;
    s = '0;
    if (r) begin
      foreach (m[i]) m[i] = '0;
      clr_act = 0;
      s.zero = 1'b1;
    end else begin
      nm = m;
      if (clr_act) begin
        nm[clr_idx] = '0;
        clr_idx++;
        if (clr_idx == D) begin
          clr_act = 0;
          s.done  = 1'b1;
        end
      end else begin
        if (we && wa >= D) s.err = 1'b1;
        if (cr) begin
          clr_act = 1;
          clr_idx = 0;
        end else if (we && wa < D) begin
          for (int b = 0; b < 2; b++)
            if (be[b]) nm[wa][8*b +: 8] = wd[8*b +: 8];
        end
      end
      if (ea) begin
        s.va = 1'b1;
        if (aa >= D) begin s.err = 1'b1; qa.push_back('0); end
        else qa.push_back(nm[aa]);
      end
      if (eb) begin
        s.vb = 1'b1;
        if (ab >= D) begin s.err = 1'b1; qb.push_back('0); end
        else qb.push_back(nm[ab]);
      end
      m = nm;
      s.busy = clr_act;
    end
    sq.push_back(s);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, 2'b00, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int a, input logic [W-1:0] d, input logic [1:0] be);
    cyc(0, 1, a, d, be, 0, 0, 0, 0, 0);
  endtask

  task automatic rda(input int a);
    cyc(0, 0, 0, '0, 2'b00, 1, a, 0, 0, 0);
  endtask

  // Monitor
  initial begin
    st_t e;
    logic [W-1:0] x;
    forever begin
      @(posedge clk);
      #1;
      if (sq.size() > 0) begin
        e = sq.pop_front();
        chk("busy",     32'(busy),     32'(e.busy));
        chk("clrDone",  32'(clrDone),  32'(e.done));
        chk("addrErr",  32'(addrErr),  32'(e.err));
        chk("rdValidA", 32'(rdValidA), 32'(e.va));
        chk("rdValidB", 32'(rdValidB), 32'(e.vb));
        if (e.zero) begin
          chk("rst_rdDataA", 32'(rdDataA), 32'h0);
          chk("rst_rdDataB", 32'(rdDataB), 32'h0);
        end
        if (rdValidA) begin
          if (qa.size() == 0) chk("rdDataA_unexpected", 32'(rdDataA), 32'hFFFF_FFFF);
          else begin x = qa.pop_front(); chk("rdDataA", 32'(rdDataA), 32'(x)); end
        end
        if (rdValidB) begin
          if (qb.size() == 0) chk("rdDataB_unexpected", 32'(rdDataB), 32'hFFFF_FFFF);
          else begin x = qb.pop_front(); chk("rdDataB", 32'(rdDataB), 32'(x)); end
        end
      end
    end
  end

  initial begin
    clr_act = 0;
    clr_idx = 0;
    foreach (m[i]) m[i] = '0;
    cyc(1, 0, 0, '0, 2'b00, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, '0, 2'b00, 0, 0, 0, 0, 0);
    // T1
    wr(0, 16'h0005, 2'b11);
    rda(0);
    idle(1);
    // T2
    wr(1, 16'd13, 2'b11);
    wr(5, 16'd25, 2'b11);
    wr(7, 16'd9, 2'b11);
    cyc(0, 0, 0, '0, 2'b00, 1, 1, 1, 5, 0);
    rda(7);
    // T3: partial-lane write, then bypassed same-cycle read
    wr(3, 16'hABCD, 2'b11);
    wr(3, 16'h1234, 2'b01);
    rda(3);
    cyc(0, 1, 3, 16'h5600, 2'b10, 1, 3, 1, 3, 0);
    wr(4, 16'hBEEF, 2'b00);
    cyc(0, 0, 0, '0, 2'b00, 1, 4, 1, 3, 0);
    // T4: no write without wrEN, out-of-range write/read
    cyc(0, 0, 0, 16'd98, 2'b11, 0, 0, 0, 0, 0);
    rda(0);
    wr(15, 16'h7777, 2'b11);
    idle(1);
    cyc(0, 1, 13, 16'h1, 2'b11, 1, 14, 1, 12, 0);
    cyc(0, 0, 0, '0, 2'b00, 1, 11, 1, 15, 0);
    idle(1);
    // T5: clear with a same-cycle write, a mid-clear write, and mid-clear reads
    cyc(0, 1, 2, 16'h4444, 2'b11, 0, 0, 0, 0, 1);
    idle(2);
    wr(2, 16'd77, 2'b11);
    cyc(0, 0, 0, '0, 2'b00, 1, 3, 1, 7, 0);
    cyc(0, 0, 0, '0, 2'b00, 1, 5, 1, 2, 1);
    idle(8);
    for (int i = 0; i < D; i++) cyc(0, 0, 0, '0, 2'b00, 1, i, 1, D - 1 - i, 0);
    // T6: reset in the middle of a clear with reads in flight
    wr(0, 16'h1111, 2'b11);
    wr(9, 16'h9999, 2'b11);
    cyc(0, 0, 0, '0, 2'b00, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, '0, 2'b00, 1, 9, 1, 0, 0);
    cyc(1, 0, 0, '0, 2'b00, 1, 9, 1, 9, 0);
    cyc(0, 0, 0, '0, 2'b00, 1, 0, 1, 9, 0);
    // Random
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 1),
          int'($urandom_range(0, 15)), W'($urandom), 2'($urandom),
          $urandom_range(0, 1), int'($urandom_range(0, 15)),
          $urandom_range(0, 1), int'($urandom_range(0, 15)),
          ($urandom_range(0, 39) == 0));
    end
    idle(D + 4);
    @(posedge clk);
    #2;
    chk("status_queue_drained", 32'(sq.size()), 32'h0);
    chk("rdA_queue_drained",    32'(qa.size()), 32'h0);
    chk("rdB_queue_drained",    32'(qb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
